// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: the FSM
// state encoding and the default operand width.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for seq_mult. It sequences IDLE -> RUN -> FIX -> DONE and
// hands the datapath one-hot strobes for operand capture, shift-add
// iterations and the sign fix-up. The datapath reports when the
// iteration is finished through run_last.
module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run_last,
  output logic busy,
  output logic done,
  output logic accept,
  output logic run_en,
  output logic fix_en
);

  state_t state;
  state_t state_nxt;

  // State register; reset wins over everything, including a pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so requests made
  // while busy or in DONE are dropped rather than queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (run_last) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; all strobes are pure functions of the current state.
  always_comb begin
    busy   = (state == RUN) || (state == FIX);
    done   = (state == DONE);
    accept = (state == IDLE) && start;
    run_en = (state == RUN);
    fix_en = (state == FIX);
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, unsigned or two's complement per
// operation. Operands are reduced to magnitudes on capture, multiplied
// one bit per RUN cycle, and the product is negated in FIX when the
// operand signs differ.
//
// Build option: define SEQ_MULT_EARLY_EXIT_EN to end RUN as soon as the
// remaining multiplier bits are all zero; otherwise RUN always lasts
// WIDTH cycles.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] pp
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [PW-1:0]    acc;
  logic [PW-1:0]    lsr;
  logic [WIDTH-1:0] rsr;
  logic [CNT_W-1:0] cnt;
  logic             sign;

  logic accept;
  logic run_en;
  logic fix_en;
  logic run_last;

  // Magnitude of an operand as an unsigned WIDTH-bit value. The most
  // negative input maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return ~v + WIDTH'(1);
    end
    return v;
  endfunction

  // Conditional two's-complement negation of a full-width product.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v,
                                               input logic          neg);
    if (neg) begin
      return ~v + PW'(1);
    end
    return v;
  endfunction

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // Finish when the multiplier bits still to be shifted in are all zero.
  assign run_last = (rsr[WIDTH-1:1] == '0);
`else
  // Finish on the last of WIDTH iterations.
  assign run_last = (cnt == CNT_W'(WIDTH - 1));
`endif

  seq_mult_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .run_last (run_last),
    .busy     (busy),
    .done     (done),
    .accept   (accept),
    .run_en   (run_en),
    .fix_en   (fix_en)
  );

  // Shift registers: load magnitudes on capture, shift once per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      lsr <= {{WIDTH{1'b0}}, magnitude(in_A, signed_mode)};
      rsr <= magnitude(in_B, signed_mode);
    end else if (run_en) begin
      lsr <= lsr << 1;
      rsr <= rsr >> 1;
    end
  end

  // Accumulator, iteration counter, sign and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      cnt  <= '0;
      sign <= 1'b0;
      pp   <= '0;
    end else if (accept) begin
      acc  <= '0;
      cnt  <= '0;
      sign <= signed_mode & (in_A[WIDTH-1] ^ in_B[WIDTH-1]);
    end else if (run_en) begin
      if (rsr[0]) begin
        acc <= acc + lsr;
      end
      cnt <= cnt + CNT_W'(1);
    end else if (fix_en) begin
      acc <= apply_sign(acc, sign);
      pp  <= apply_sign(acc, sign);
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed corner cases on an 8-bit
// instance and randomized operands on a 16-bit instance, compared with
// an arithmetic reference of the product and the expected latency.
module tb_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset8, start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] pp8;

  logic        reset16, start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] pp16;

  int n_checks = 0;
  int n_errors = 0;

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .signed_mode(sm8),
    .in_A(a8), .in_B(b8), .busy(busy8), .done(done8), .pp(pp8)
  );

  seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset16), .start(start16), .signed_mode(sm16),
    .in_A(a16), .in_B(b16), .busy(busy16), .done(done16), .pp(pp16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product: interpret operands as integers, multiply, wrap to 2w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic sm);
    longint mask;
    longint va;
    longint vb;
    longint p;
    mask = (longint'(1) << w) - 1;
    va = longint'(a) & mask;
    vb = longint'(b) & mask;
    if (sm && va[w-1]) va = va - (longint'(1) << w);
    if (sm && vb[w-1]) vb = vb - (longint'(1) << w);
    p = va * vb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Reference latency in cycles from the accepting edge to done.
  function automatic int ref_latency(input int w, input logic [31:0] b, input logic sm);
    longint mag;
    int     k;
    mag = longint'(b) & ((longint'(1) << w) - 1);
    if (sm && mag[w-1]) mag = (longint'(1) << w) - mag;
    k = 1;
    for (int i = 0; i < w; i++) if (mag[i]) k = i + 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    return k + 2;
`else
    return (k > 0) ? w + 2 : w + 2;
`endif
  endfunction

  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input logic st);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; start8 = st;
    end else begin
      a16 = a[15:0]; b16 = b[15:0]; sm16 = sm; start16 = st;
    end
  endtask

  task automatic set_start(input int w, input logic st);
    if (w == 8) start8 = st;
    else start16 = st;
  endtask

  function automatic logic f_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  function automatic logic f_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic [31:0] f_pp(input int w);
    return (w == 8) ? {16'h0, pp8} : pp16;
  endfunction

  // One full operation. Operands are scrambled right after acceptance;
  // inj > 0 pulses start again in that busy cycle, which must be ignored.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input int inj, input string tag);
    logic [63:0] exp_pp;
    int          exp_lat;
    int          cyc;
    bit          busy_ok;
    exp_pp  = ref_prod(w, a, b, sm);
    exp_lat = ref_latency(w, b, sm);
    busy_ok = 1'b1;
    @(negedge clk);
    drive(w, a, b, sm, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(w, $urandom, $urandom, ~sm, 1'b0);
    cyc = 1;
    while (!f_done(w) && cyc < 64) begin
      if (!f_busy(w)) busy_ok = 1'b0;
      set_start(w, cyc == inj);
      @(negedge clk);
      cyc++;
    end
    set_start(w, 1'b0);
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " busy during op"}, 64'(busy_ok), 64'd1);
    check({tag, " pp"}, 64'(f_pp(w)), exp_pp);
    check({tag, " busy at done"}, 64'(f_busy(w)), 64'd0);
    @(negedge clk);
    check({tag, " done single pulse"}, 64'(f_done(w)), 64'd0);
    check({tag, " pp held"}, 64'(f_pp(w)), exp_pp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] ra, rb;
    reset8 = 1'b1; reset16 = 1'b1;
    drive(8, 0, 0, 1'b0, 1'b0);
    drive(16, 0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset8 = 1'b0; reset16 = 1'b0;

    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset pp8", 64'(pp8), 64'd0);
    check("reset busy16", 64'(busy16), 64'd0);
    check("reset done16", 64'(done16), 64'd0);
    check("reset pp16", 64'(pp16), 64'd0);

    // Directed 8-bit products
    do_op(8, 200, 150, 1'b0, 0, "u200x150");
    check("u200x150 const", 64'(pp8), 64'd30000);
    do_op(8, 8'h80, 8'h80, 1'b1, 0, "s-128x-128");
    check("s-128x-128 const", 64'(pp8), 64'd16384);
    do_op(8, 8'hF9, 8'd9, 1'b1, 0, "s-7x9");
    check("s-7x9 const", 64'(pp8), 64'hFFC1);
    do_op(8, 8'hFF, 8'hFF, 1'b0, 0, "u255x255");
    do_op(8, 8'h7F, 8'h80, 1'b1, 0, "s127x-128");
    do_op(8, 8'h80, 8'h7F, 1'b0, 0, "u128x127");
    do_op(8, 5, 3, 1'b0, 0, "u5x3");
    check("u5x3 const", 64'(pp8), 64'd15);
    do_op(8, 77, 0, 1'b0, 0, "u77x0");
    check("u77x0 const", 64'(pp8), 64'd0);

    // Start pulsed while busy is ignored
    do_op(8, 13, 8'hA5, 1'b0, 4, "start-while-busy");
    repeat (3) @(negedge clk);
    check("no second op busy", 64'(busy8), 64'd0);
    check("no second op pp", 64'(pp8), 64'd2145);

    // Reset in the 5th RUN cycle aborts the operation
    @(negedge clk);
    drive(8, 100, 100, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    reset8 = 1'b1;
    @(negedge clk);
    reset8 = 1'b0;
    check("midrun reset busy", 64'(busy8), 64'd0);
    check("midrun reset done", 64'(done8), 64'd0);
    check("midrun reset pp", 64'(pp8), 64'd0);
    do_op(8, 100, 100, 1'b0, 0, "after reset");

    // Start coincident with reset is ignored
    @(negedge clk);
    drive(8, 9, 9, 1'b0, 1'b1);
    reset8 = 1'b1;
    @(negedge clk);
    reset8 = 1'b0;
    start8 = 1'b0;
    check("start with reset ignored", 64'(busy8), 64'd0);

    // Start held high: a new operation begins in the IDLE cycle after DONE
    @(negedge clk);
    drive(8, 12, 11, 1'b0, 1'b1);
    cyc = 0;
    while (!done8 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("held start first done", 64'(done8), 64'd1);
    check("held start first pp", 64'(pp8), 64'd132);
    @(negedge clk);
    check("held start idle gap", 64'(busy8), 64'd0);
    a8 = 8'd20;
    @(negedge clk);
    check("held start re-accept", 64'(busy8), 64'd1);
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("held start second pp", 64'(pp8), 64'd220);

    // 16-bit: extreme operand, then randomized pairs in both modes
    do_op(16, 32'h8000, 32'h8000, 1'b1, 0, "s16 min x min");
    check("s16 min x min const", 64'(pp16), 64'h4000_0000);
    for (int i = 0; i < 1000; i++) begin
      ra = 32'($urandom_range(0, 65535));
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15))
                                       : 32'($urandom_range(0, 65535));
      do_op(16, ra, rb, logic'(i % 2), 0, "rand16");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a multiply; it is sampled only in IDLE.
REQ-005 signed_mode  input  1  SHALL select the operand encoding: 1 = two's complement, 0 = unsigned; it is sampled with start.
REQ-006 in_A  input  WIDTH  SHALL be the multiplicand, sampled with start.
REQ-007 in_B  input  WIDTH  SHALL be the multiplier, sampled with start.
REQ-008 busy  output  1  SHALL be high in RUN and FIX states.
REQ-009 done  output  1  SHALL be a one-cycle pulse in the DONE state.
REQ-010 pp  output  2*WIDTH  SHALL be the product, valid from done until the next accepted start.

Function
REQ-011 The FSM SHALL have four states: IDLE, RUN, FIX, DONE.
REQ-012 Transitions SHALL be: IDLE->RUN on start; RUN->FIX when the iteration ends; FIX->DONE unconditionally; DONE->IDLE unconditionally.
REQ-013 On accepting start, operands SHALL be captured as follows:
- The accumulator SHALL be cleared.
- The iteration counter SHALL be cleared.
- In signed mode, the magnitude of each operand SHALL be loaded into the shift registers.
- The result sign SHALL be latched as in_A[MSB] XOR in_B[MSB]; it SHALL be 0 in unsigned mode.
REQ-014 Each RUN cycle SHALL perform one shift-add step:
- Add the left-shift register (2*WIDTH bits) to the accumulator if the right-shift register LSB is 1.
- Shift the left register left by 1.
- Shift the right register right by 1.
- Increment the counter.
REQ-015 RUN SHALL end after exactly WIDTH cycles, except as given in REQ-026.
REQ-016 FIX SHALL two's-complement-negate the accumulator if the latched sign is 1; otherwise it SHALL hold the accumulator.
REQ-017 pp SHALL be updated only on the FIX->DONE edge.
- Total latency from the start-sampling edge to done SHALL be WIDTH+2 cycles.
REQ-018 All arithmetic SHALL be 2*WIDTH bits wide and SHALL never overflow.
- The magnitude of the most negative operand (2^(WIDTH-1)) SHALL be represented as unsigned WIDTH bits.
REQ-019 start while busy or in DONE SHALL be ignored; no queuing.
REQ-020 start asserted continuously SHALL begin a new operation in the IDLE cycle following DONE.
REQ-021 Operand or signed_mode changes after acceptance SHALL have no effect on the running operation.

Reset
REQ-022 When reset is high at a clock edge, the block SHALL return to IDLE from any state, including mid-RUN or mid-FIX.
REQ-023 Reset values SHALL be: busy=0, done=0, pp=0, accumulator=0, counter=0, sign=0.
REQ-024 A start coincident with reset SHALL be ignored; reset has priority.

Configuration
REQ-025 The macro SEQ_MULT_EARLY_EXIT_EN SHALL control early termination of RUN.
REQ-026 With SEQ_MULT_EARLY_EXIT_EN defined, RUN SHALL end in the cycle when the next right-shift register value is zero.
- Latency SHALL be k+2 cycles, where k is the bit position of the highest set bit of |B| plus 1.
- For |B|=0, k SHALL be 1.
REQ-027 With SEQ_MULT_EARLY_EXIT_EN undefined, RUN SHALL always last WIDTH cycles, and no zero-detect logic SHALL be present.

Structure
REQ-028 A shared package seq_mult_pkg SHALL hold:
- the FSM state typedef (IDLE, RUN, FIX, DONE);
- the constant DEFAULT_WIDTH = 8.
REQ-029 The counter width SHALL be derived in-module as $clog2(WIDTH+1).
REQ-030 One sub-module, seq_mult_ctrl (the FSM), SHALL be instantiated.
- The datapath (shift registers, accumulator, counter) SHALL remain in seq_mult.

Verification
REQ-031 Unsigned, WIDTH=8: in_A=200, in_B=150, signed_mode=0 -> pp=30000; done exactly 10 cycles after start sampled.
REQ-032 Signed, WIDTH=8: in_A=-128, in_B=-128 -> pp=16384. Signed: in_A=-7, in_B=9 -> pp=-63 (0xFFC1).
REQ-033 start pulsed while busy in cycle 4 -> ignored; pp matches the first operands; exactly one done pulse.
REQ-034 reset asserted in the 5th RUN cycle -> next cycle IDLE, busy=0, pp=0; a later start yields a correct product.
REQ-035 With SEQ_MULT_EARLY_EXIT_EN defined, WIDTH=8:
- in_B=3, in_A=5 -> pp=15, done 4 cycles after start.
- in_B=0 -> pp=0, done 3 cycles after start.
REQ-036 WIDTH=16, randomized 1000 operand pairs in both modes -> pp equals the reference product, busy/done protocol holds.
